cpu_run_ctrl: RTL

- Parametrised successor to the controller's debug-control section. Owns CPU run state: reset stretching, run, halt, and single- or N-step execution.
- Adds a breakpoint table with NUM_BP entries, a soft-reset request and a halt request.
- Sits beside the decoder and drives cpu_rst/cpu_en into every pipeline stage register of the 5-stage datapath.

---
 rtl/cpu_run_pkg.sv | 12 +
 rtl/cpu_run_ctrl_bp_match.sv | 51 +++++
 rtl/cpu_run_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: run-state encoding and breakpoint index sizing shared by the run controller
package cpu_run_pkg;
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;
  function automatic int bp_idx_w(input int num_bp);
    return $clog2(num_bp);
  endfunction
endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// cpu_run_ctrl_bp_match: breakpoint table with word-granular PC compare and lowest-index priority
module cpu_run_ctrl_bp_match
  import cpu_run_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BP     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wen,
  input  logic [bp_idx_w(NUM_BP)-1:0]   widx,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic                          wvalid,
  input  logic [ADDR_WIDTH-1:0]         pc,
  output logic                          match,
  output logic [bp_idx_w(NUM_BP)-1:0]   match_idx
);
  localparam int IW = bp_idx_w(NUM_BP);
  logic [NUM_BP-1:0]       valid_q, valid_d;
  logic [ADDR_WIDTH-1:2]   addr_q [NUM_BP];
  logic [ADDR_WIDTH-1:2]   addr_d [NUM_BP];
  logic                    unused_lo;
  assign unused_lo = ^{waddr[1:0], pc[1:0]};
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (wen) begin
      valid_d[widx] = wvalid;
      addr_d[widx]  = waddr[ADDR_WIDTH-1:2];
    end
  end
  // Descending scan so the lowest matching entry is the one left standing
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (valid_q[i] && addr_q[i] == pc[ADDR_WIDTH-1:2]) begin
        match     = 1'b1;
        match_idx = IW'(i);
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: pipeline reset/enable sequencing with run, halt, N-step and breakpoint stops
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BP     = 4,
  parameter int STEP_W     = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          debug_en,
  input  logic                          debug_step,
  input  logic [STEP_W-1:0]             step_count,
  input  logic                          halt_req,
  input  logic                          resume,
  input  logic                          sw_rst,
  input  logic                          bp_wen,
  input  logic [bp_idx_w(NUM_BP)-1:0]   bp_idx,
  input  logic [ADDR_WIDTH-1:0]         bp_addr,
  input  logic                          bp_valid,
  input  logic [ADDR_WIDTH-1:0]         pc_if,
  output logic                          cpu_rst,
  output logic                          cpu_en,
  output logic                          halted,
  output logic                          bp_hit,
  output logic [bp_idx_w(NUM_BP)-1:0]   bp_hit_idx,
  output logic [STEP_W-1:0]             steps_left
);
  localparam int IW = bp_idx_w(NUM_BP);
  localparam int CW = $clog2(RST_CYCLES + 1);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              skip_q, skip_d;
  logic              hit_q, hit_d;
  logic [IW-1:0]     hit_idx_q, hit_idx_d;
  logic              s1_q, s2_q, s3_q;
  logic              step_pulse, match, bp_stop;
  logic [IW-1:0]     match_idx;
  cpu_run_ctrl_bp_match #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_BP(NUM_BP)) u_bp (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (bp_wen),
    .widx      (bp_idx),
    .waddr     (bp_addr),
    .wvalid    (bp_valid),
    .pc        (pc_if),
    .match     (match),
    .match_idx (match_idx)
  );
  assign step_pulse = s2_q & ~s3_q;
  assign bp_stop    = match & ~skip_q & (state_q == RUN || state_q == STEP);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    skip_d    = skip_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    cpu_en    = 1'b0;
    case (state_q)
      HOLD: begin
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q != '0 ? HOLD : debug_en ? HALT : RUN;
      end
      RUN: begin
        cpu_en  = ~bp_stop;
        skip_d  = 1'b0;
        state_d = bp_stop || debug_en || halt_req ? HALT : RUN;
      end
      HALT: begin
        if (step_pulse) begin
          state_d = STEP;
          steps_d = step_count == '0 ? STEP_W'(1) : step_count;
          skip_d  = 1'b1;
        end else if (resume && !debug_en) begin
          state_d = RUN;
          hit_d   = 1'b0;
          skip_d  = 1'b1;
        end
      end
      STEP: begin
        cpu_en = ~bp_stop;
        skip_d = 1'b0;
        if (bp_stop || halt_req) state_d = HALT;
        else if (steps_q == STEP_W'(1)) begin
          state_d = HALT;
          steps_d = '0;
        end else steps_d = steps_q - 1'b1;
      end
    endcase
    if (bp_stop) begin
      hit_d     = 1'b1;
      hit_idx_d = match_idx;
    end
    if (sw_rst) begin
      state_d = HOLD;
      cnt_d   = CW'(RST_CYCLES - 1);
      steps_d = '0;
      skip_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= CW'(RST_CYCLES - 1);
      steps_q   <= '0;
      skip_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      skip_q    <= skip_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      s1_q      <= debug_step;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end
  assign cpu_rst    = state_q == HOLD;
  assign halted     = state_q == HALT;
  assign bp_hit     = hit_q;
  assign bp_hit_idx = hit_idx_q;
  assign steps_left = steps_q;
endmodule
